logic_op_arbiter: RTL and testbench

Shares one WIDTH-bit bitwise logic unit (AND/OR/NOT/XOR/XNOR/NAND/NOR) among N_REQ requesters. Uses round-robin arbitration, a valid/ready handshake on each request port, and a single registered response port tagged with the requester index. It sits between the requesting blocks and the logic datapath, so the datapath is never driven by two requesters at once.

---
 rtl/logic_op_pkg.sv | 19 +
 rtl/logic_op_arbiter_logic_unit.sv | 34 +++
 rtl/logic_op_arbiter.sv | 149 ++++++++++++++
 tb/tb_logic_op_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/logic_op_pkg.sv
// Shared op-code and FSM encodings for the shared bitwise logic unit and its arbiter.
package logic_op_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_XOR  = 3'd3;
    localparam logic [2:0] OP_XNOR = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_arbiter_logic_unit.sv
// Combinational WIDTH-bit bitwise logic unit; the reserved op yields zero with err set.
module logic_unit
    import logic_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    // Op decode
    always_comb begin
        y   = {WIDTH{1'b0}};
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOT:  y = ~a;
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_RSVD: err = 1'b1;
            default: begin
                y   = {WIDTH{1'b0}};
                err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among N_REQ valid/ready requesters,
// with a single registered, requester-tagged response port.
module logic_op_arbiter
    import logic_op_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [3*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_err
);

    state_t           state_r, state_next_s;
    logic [ID_W-1:0]  rr_ptr_r;
    logic [ID_W-1:0]  winner_s;
    logic             found_s;
    logic [N_REQ-1:0] grant_s;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r, b_r;
    logic [ID_W-1:0]  id_r;
    logic [WIDTH-1:0] unit_y_s;
    logic             unit_err_s;
    logic             rsp_valid_r;
    logic [ID_W-1:0]  rsp_id_r;
    logic [WIDTH-1:0] rsp_data_r;
    logic             rsp_err_r;

    // Round-robin search starting at rr_ptr, wrapping modulo N_REQ
    always_comb begin
        logic [ID_W:0] idx_v;
        idx_v    = {(ID_W+1){1'b0}};
        found_s  = 1'b0;
        winner_s = {ID_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            idx_v = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
            if (idx_v >= (ID_W+1)'(N_REQ)) begin
                idx_v = idx_v - (ID_W+1)'(N_REQ);
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && req_valid[idx_v[ID_W-1:0]]) begin
                found_s  = 1'b1;
                winner_s = idx_v[ID_W-1:0];
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant only from IDLE; reset forces it low so nothing is accepted while held
    always_comb begin
        grant_s = {N_REQ{1'b0}};
        if (rst_n && (state_r == IDLE) && found_s) begin
            grant_s[winner_s] = 1'b1;
        end else begin
            grant_s = {N_REQ{1'b0}};
        end
    end

    assign req_ready = grant_s;

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (found_s) state_next_s = EXEC;
                else         state_next_s = IDLE;
            end
            EXEC:    state_next_s = RESP;
            RESP: begin
                if (rsp_ready) state_next_s = IDLE;
                else           state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_next_s;
    end

    logic_unit #(.WIDTH(WIDTH)) u_logic_unit (
        .op  (op_r),
        .a   (a_r),
        .b   (b_r),
        .y   (unit_y_s),
        .err (unit_err_s)
    );

    // Request latch, response registers and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r    <= {ID_W{1'b0}};
            op_r        <= 3'd0;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            id_r        <= {ID_W{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= {ID_W{1'b0}};
            rsp_data_r  <= {WIDTH{1'b0}};
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        op_r <= req_op[3*winner_s +: 3];
                        a_r  <= req_a[WIDTH*winner_s +: WIDTH];
                        b_r  <= req_b[WIDTH*winner_s +: WIDTH];
                        id_r <= winner_s;
                    end
                end
                EXEC: begin
                    rsp_valid_r <= 1'b1;
                    rsp_id_r    <= id_r;
                    rsp_data_r  <= unit_y_s;
                    rsp_err_r   <= unit_err_s;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        if ({1'b0, rsp_id_r} == (ID_W+1)'(N_REQ - 1)) rr_ptr_r <= {ID_W{1'b0}};
                        else                                          rr_ptr_r <= rsp_id_r + ID_W'(1);
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed self-checking bench for logic_op_arbiter (N_REQ=4, WIDTH=8).
module tb_logic_op_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic_op_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single isolated transaction from requester id with operands F0/3C; entered at a negedge in IDLE.
    task automatic run_txn(input int id, input logic [2:0] op, input logic [7:0] exp_d, input logic exp_e);
        req_valid = 4'b0000;
        req_valid[id] = 1'b1;
        req_op[3*id +: 3] = op;
        req_a[8*id +: 8] = 8'hF0;
        req_b[8*id +: 8] = 8'h3C;
        #1 check_eq("txn_grant", 32'(req_ready), 32'(1) << id);
        check_eq("txn_idle_rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        check_eq("txn_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("txn_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("txn_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("txn_rsp_id", 32'(rsp_id), 32'(id));
        check_eq("txn_rsp_data", 32'(rsp_data), 32'(exp_d));
        check_eq("txn_rsp_err", 32'(rsp_err), 32'(exp_e));
        @(negedge clk);
        check_eq("txn_rsp_cleared", 32'(rsp_valid), 32'd0);
    endtask

    logic [7:0] sweep_exp [8];
    logic [7:0] rr_exp    [4];
    logic [1:0] rr_order  [5];
    logic [7:0] held_data;

    initial begin
        sweep_exp = '{8'h30, 8'hFC, 8'h0F, 8'hCC, 8'h33, 8'hCF, 8'h03, 8'h00};
        rr_exp    = '{8'h30, 8'hFC, 8'h0F, 8'hCC};
        rr_order  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_op    = 12'd0;
        req_a     = 32'hF0F0_F0F0;
        req_b     = 32'h3C3C_3C3C;
        rsp_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 4'b0000;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("idle_no_req_ready", 32'(req_ready), 32'd0);

        // Single request, requester 0, AND
        run_txn(0, 3'd0, 8'h30, 1'b0);

        // Op sweep on requester 2
        for (int op = 0; op < 8; op++) begin
            run_txn(2, 3'(op), sweep_exp[op], (op == 7) ? 1'b1 : 1'b0);
        end

        // Round-robin from a fresh pointer
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_op    = {3'd3, 3'd2, 3'd1, 3'd0};
        req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            #1 check_eq("rr_grant", 32'(req_ready), 32'(1) << rr_order[g]);
            @(negedge clk);
            @(negedge clk);
            check_eq("rr_rsp_id", 32'(rsp_id), 32'(rr_order[g]));
            check_eq("rr_rsp_data", 32'(rsp_data), 32'(rr_exp[rr_order[g]]));
            @(negedge clk);
        end
        req_valid = 4'b0000;

        // Backpressure: pointer is now 1, so requester 0 alone is found after wrapping
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1 check_eq("bp_grant0", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 4'b0010;
        #1 check_eq("bp_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
        held_data = rsp_data;
        check_eq("bp_rsp_data", 32'(held_data), 32'h30);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_hold_id", 32'(rsp_id), 32'd0);
            check_eq("bp_hold_data", 32'(rsp_data), 32'h30);
            check_eq("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1 check_eq("bp_resp_ready_no_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("bp_after_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("bp_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("bp_rsp_id1", 32'(rsp_id), 32'd1);
        check_eq("bp_rsp_data1", 32'(rsp_data), 32'hFC);
        @(negedge clk);

        // Reset during EXEC discards the transaction
        req_valid = 4'b0100;
        req_op[8:6] = 3'd3;
        #1 check_eq("mid_grant2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1 check_eq("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("mid_rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1 check_eq("mid_release_grant1", 32'(req_ready), 32'b0010);
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
        check_eq("mid_rsp_id1", 32'(rsp_id), 32'd1);

        // Drop before grant: requester 3 pulses while in RESP
        req_valid = 4'b1000;
        #1 check_eq("drop_ready_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        check_eq("drop_still_resp", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check_eq("drop_no_rsp", 32'(rsp_valid), 32'd0);
        check_eq("drop_no_grant", 32'(req_ready), 32'd0);
        @(negedge clk);
        check_eq("drop_idle_no_rsp", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1101;
        #1 check_eq("drop_rr_ptr2", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        check_eq("drop_final_id", 32'(rsp_id), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
